// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: flag register plus a small FIFO of pending register-file writes.
// Optional 2-entry skid buffer enabled by `define ALU_WB_SKID_BUFFER_EN (default: 1 entry).

package CPU_package;
    localparam int DATA_WIDTH = 16;

    typedef struct packed {
        logic overflow_flag;
        logic negative_flag;
        logic zero_flag;
        logic carry_flag;
    } struct_alu_flag_t;
endpackage

module alu_writeback_stage #(
    parameter int DATA_WIDTH     = CPU_package::DATA_WIDTH,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH-1:0]              in_result,
    input  CPU_package::struct_alu_flag_t      in_flags,
    input  logic [REG_ADDR_WIDTH-1:0]          in_dest,
    input  logic                               in_reg_we,
    input  logic                               in_flag_we,
    input  logic                               flush,
    output logic                               rf_wr_en,
    output logic [REG_ADDR_WIDTH-1:0]          rf_wr_addr,
    output logic [DATA_WIDTH-1:0]              rf_wr_data,
    input  logic                               rf_wr_ready,
    output CPU_package::struct_alu_flag_t      flags_q,
    output logic                               carry_to_alu,
    output logic [1:0]                         occupancy
);

`ifdef ALU_WB_SKID_BUFFER_EN
    localparam int OCC_W = 2;
`else
    localparam int OCC_W = 1;
`endif

    logic [OCC_W-1:0]               occ_q, occ_d;
    logic [REG_ADDR_WIDTH-1:0]      head_addr_q, head_addr_d;
    logic [DATA_WIDTH-1:0]          head_data_q, head_data_d;
    CPU_package::struct_alu_flag_t  flags_d;
`ifdef ALU_WB_SKID_BUFFER_EN
    logic [REG_ADDR_WIDTH-1:0]      tail_addr_q, tail_addr_d;
    logic [DATA_WIDTH-1:0]          tail_data_q, tail_data_d;
`endif

    logic accept;
    logic push;
    logic pop;

    // in_ready never depends on in_valid, so accept has no loop through the ALU.
`ifdef ALU_WB_SKID_BUFFER_EN
    assign in_ready  = (occ_q != 2'd2);
    assign occupancy = occ_q;
`else
    assign in_ready  = (occ_q == 1'b0) || rf_wr_ready;
    assign occupancy = {1'b0, occ_q};
`endif

    assign accept       = in_valid && in_ready && !flush;
    assign push         = accept && in_reg_we;
    assign rf_wr_en     = (occ_q != '0);
    assign pop          = rf_wr_en && rf_wr_ready;
    assign rf_wr_addr   = head_addr_q;
    assign rf_wr_data   = head_data_q;
    assign carry_to_alu = flags_q.carry_flag;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
        occ_d       = occ_q;
        head_addr_d = head_addr_q;
        head_data_d = head_data_q;
        flags_d     = flags_q;
`ifdef ALU_WB_SKID_BUFFER_EN
        tail_addr_d = tail_addr_q;
        tail_data_d = tail_data_q;
`endif

        // Flags commit at acceptance so a chained op sees the new carry immediately.
        if (accept && in_flag_we) begin
            flags_d = in_flags;
        end

        if (flush) begin
            occ_d = '0;
        end else begin
`ifdef ALU_WB_SKID_BUFFER_EN
            unique case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_addr_d = in_dest;
                        head_data_d = in_result;
                    end else begin
                        tail_addr_d = in_dest;
                        tail_data_d = in_result;
                    end
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    head_addr_d = tail_addr_q;
                    head_data_d = tail_data_q;
                    occ_d       = occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_addr_d = in_dest;
                        head_data_d = in_result;
                    end else begin
                        head_addr_d = tail_addr_q;
                        head_data_d = tail_data_q;
                        tail_addr_d = in_dest;
                        tail_data_d = in_result;
                    end
                end
                default: ;
            endcase
`else
            if (push) begin
                head_addr_d = in_dest;
                head_data_d = in_result;
                occ_d       = 1'b1;
            end else if (pop) begin
                occ_d = 1'b0;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: buffer payload registers are reset too, because the write port must read zero out of reset.
            occ_q       <= '0;
            head_addr_q <= '0;
            head_data_q <= '0;
            flags_q     <= '0;
`ifdef ALU_WB_SKID_BUFFER_EN
            tail_addr_q <= '0;
            tail_data_q <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            occ_q       <= occ_d;
            head_addr_q <= head_addr_d;
            head_data_q <= head_data_d;
            flags_q     <= flags_d;
`ifdef ALU_WB_SKID_BUFFER_EN
            tail_addr_q <= tail_addr_d;
            tail_data_q <= tail_data_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed self-checking bench for alu_writeback_stage; expectations follow the build's
// ALU_WB_SKID_BUFFER_EN setting (2-entry skid buffer vs 1-entry pass-through).

module tb_alu_writeback_stage;
    import CPU_package::*;

`ifdef ALU_WB_SKID_BUFFER_EN
    localparam int MAX_OCC = 2;
`else
    localparam int MAX_OCC = 1;
`endif

    logic                  clk;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [15:0]           in_result;
    struct_alu_flag_t      in_flags;
    logic [2:0]            in_dest;
    logic                  in_reg_we;
    logic                  in_flag_we;
    logic                  flush;
    logic                  rf_wr_en;
    logic [2:0]            rf_wr_addr;
    logic [15:0]           rf_wr_data;
    logic                  rf_wr_ready;
    struct_alu_flag_t      flags_q;
    logic                  carry_to_alu;
    logic [1:0]            occupancy;

    int checks = 0;
    int errors = 0;

    alu_writeback_stage dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_flags     (in_flags),
        .in_dest      (in_dest),
        .in_reg_we    (in_reg_we),
        .in_flag_we   (in_flag_we),
        .flush        (flush),
        .rf_wr_en     (rf_wr_en),
        .rf_wr_addr   (rf_wr_addr),
        .rf_wr_data   (rf_wr_data),
        .rf_wr_ready  (rf_wr_ready),
        .flags_q      (flags_q),
        .carry_to_alu (carry_to_alu),
        .occupancy    (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid   = 1'b0;
        in_result  = '0;
        in_flags   = '0;
        in_dest    = '0;
        in_reg_we  = 1'b0;
        in_flag_we = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic present(input logic [15:0] res, input logic [2:0] dst, input logic reg_we,
                           input logic flag_we, input logic [3:0] flg);
        in_valid   = 1'b1;
        in_result  = res;
        in_dest    = dst;
        in_reg_we  = reg_we;
        in_flag_we = flag_we;
        in_flags   = flg;
    endtask

    logic [15:0] vals [3];
    logic [15:0] retired [8];
    int          n_acc;
    int          n_ret;
    int          pulses;

    initial begin
        vals[0] = 16'h0011;
        vals[1] = 16'h0022;
        vals[2] = 16'h0033;
        idle_inputs();
        rf_wr_ready = 1'b0;
        rst = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_occ", 32'(occupancy), 0);
        check("rst_wr_en", 32'(rf_wr_en), 0);
        check("rst_addr", 32'(rf_wr_addr), 0);
        check("rst_data", 32'(rf_wr_data), 0);
        check("rst_flags", 32'(flags_q), 0);
        check("rst_carry", 32'(carry_to_alu), 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 1);

        // Single write: visible one cycle after accept, gone after retire
        @(negedge clk);
        rf_wr_ready = 1'b1;
        present(16'h0003, 3'd2, 1'b1, 1'b0, 4'h0);
        @(negedge clk);
        idle_inputs();
        check("wr_en", 32'(rf_wr_en), 1);
        check("wr_addr", 32'(rf_wr_addr), 2);
        check("wr_data", 32'(rf_wr_data), 16'h0003);
        check("wr_occ1", 32'(occupancy), 1);
        @(negedge clk);
        check("wr_occ0", 32'(occupancy), 0);
        check("wr_en_low", 32'(rf_wr_en), 0);

        // Backpressure: offer three results with the register file stalled
        rf_wr_ready = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 4; c++) begin
            if (n_acc < 3) present(vals[n_acc], 3'd5, 1'b1, 1'b0, 4'h0);
            else idle_inputs();
            #1;
            if (in_valid && in_ready) n_acc++;
            @(negedge clk);
        end
        check("bp_accepts", 32'(n_acc), 32'(MAX_OCC));
        check("bp_occ", 32'(occupancy), 32'(MAX_OCC));
        check("bp_in_ready", 32'(in_ready), 0);
        check("bp_head_hold", 32'(rf_wr_data), 16'h0011);

        // Release: drain in order while feeding the rest
        rf_wr_ready = 1'b1;
        n_ret = 0;
        for (int c = 0; c < 10; c++) begin
            if (n_acc < 3) present(vals[n_acc], 3'd5, 1'b1, 1'b0, 4'h0);
            else idle_inputs();
            #1;
            if (rf_wr_en && rf_wr_ready) begin
                if (n_ret < 8) retired[n_ret] = rf_wr_data;
                n_ret++;
            end
            if (in_valid && in_ready) n_acc++;
            @(negedge clk);
        end
        idle_inputs();
        check("bp_retire_count", 32'(n_ret), 3);
        for (int i = 0; i < 3; i++) check($sformatf("bp_order%0d", i), 32'(retired[i]), 32'(vals[i]));
        check("bp_drained", 32'(occupancy), 0);

        // Compare op: flags only, no register write
        present(16'h1234, 3'd1, 1'b0, 1'b1, 4'b0011);
        pulses = 0;
        @(negedge clk);
        idle_inputs();
        check("cpr_flags", 32'(flags_q), 4'b0011);
        check("cpr_carry", 32'(carry_to_alu), 1);
        for (int c = 0; c < 3; c++) begin
            if (rf_wr_en) pulses++;
            @(negedge clk);
        end
        check("cpr_no_write", 32'(pulses), 0);

        // Flush: clear flags first, fill the buffer, then flush with a carrying accept
        present(16'h0000, 3'd0, 1'b0, 1'b1, 4'b0000);
        @(negedge clk);
        rf_wr_ready = 1'b0;
        for (int c = 0; c < MAX_OCC; c++) begin
            present(16'h0040 + 16'(c), 3'd3, 1'b1, 1'b0, 4'h0);
            @(negedge clk);
        end
        check("fl_pre_occ", 32'(occupancy), 32'(MAX_OCC));
        present(16'h0099, 3'd4, 1'b1, 1'b1, 4'b0001);
        flush = 1'b1;
        @(negedge clk);
        idle_inputs();
        check("fl_occ", 32'(occupancy), 0);
        check("fl_wr_en", 32'(rf_wr_en), 0);
        check("fl_flags_kept", 32'(flags_q), 0);
        check("fl_carry_kept", 32'(carry_to_alu), 0);

        // Asynchronous reset mid-cycle with an entry pending
        present(16'hBEEF, 3'd6, 1'b1, 1'b1, 4'b0001);
        @(negedge clk);
        idle_inputs();
        check("mr_pre_occ", 32'(occupancy), 1);
        check("mr_pre_carry", 32'(carry_to_alu), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mr_wr_en", 32'(rf_wr_en), 0);
        check("mr_data", 32'(rf_wr_data), 0);
        check("mr_flags", 32'(flags_q), 0);
        check("mr_carry", 32'(carry_to_alu), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mr_in_ready", 32'(in_ready), 1);

        // Carry chaining: FFFF+1 -> 0 with carry, then 0+0+cin -> 1 without carry
        @(negedge clk);
        rf_wr_ready = 1'b1;
        present(16'h0000, 3'd1, 1'b1, 1'b1, 4'b0011);
        @(negedge clk);
        check("cc_carry1", 32'(carry_to_alu), 1);
        check("cc_data1", 32'(rf_wr_data), 16'h0000);
        present(16'h0001, 3'd2, 1'b1, 1'b1, 4'b0000);
        @(negedge clk);
        idle_inputs();
        check("cc_carry2", 32'(carry_to_alu), 0);
        check("cc_data2", 32'(rf_wr_data), 16'h0001);
        check("cc_addr2", 32'(rf_wr_addr), 2);
        @(negedge clk);
        check("cc_drained", 32'(occupancy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
